alu_share_arbiter: RTL and testbench

// Shares one combinational ALU instance between two requesters: req0 is the CPU execute stage and
// req1 is the game-logic engine (collision/score math). Each request is captured, driven into the
// ALU for ALU_LATENCY cycles, then returned to its owner over a valid/ready response channel.

---
 rtl/alu_share_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between the CPU execute stage (req0) and the
// game-logic engine (req1); a single operation is in flight at any time.
module alu_share_arbiter #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ALU_LATENCY   = 1,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_opA,
    input  logic [WIDTH-1:0] req0_opB,
    input  logic [4:0]       req0_opcode,
    input  logic [4:0]       req0_shamt,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_opA,
    input  logic [WIDTH-1:0] req1_opB,
    input  logic [4:0]       req1_opcode,
    input  logic [4:0]       req1_shamt,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ne,
    output logic             rsp_lt,
    output logic             rsp_ovf,

    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [4:0]       alu_opcode,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ne,
    input  logic             alu_lt,
    input  logic             alu_ovf,

    output logic             busy
);

    localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam bit FIXED_PRIO = (PRIORITY_MODE != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic grant0_c;
    logic grant1_c;
    logic req_hs_c;
    logic rsp_hs_c;

    // Arbitration: a lone requester wins; on contention either fixed req0 or round-robin.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO || last_grant) begin
                grant0_c = 1'b1;
            end else begin
                grant1_c = 1'b1;
            end
        end else begin
            grant0_c = req0_valid;
            grant1_c = req1_valid;
        end
    end

    // Ready is gated by reset so every output reads zero while reset is held.
    assign req0_ready = reset_n && (state == S_IDLE) && grant0_c;
    assign req1_ready = reset_n && (state == S_IDLE) && grant1_c;

    assign req_hs_c = req0_ready || req1_ready;
    assign rsp_hs_c = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_hs_c) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_hs_c) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, latency count and result capture; alu_* are the capture registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_opA    <= '0;
            alu_opB    <= '0;
            alu_opcode <= '0;
            alu_shamt  <= '0;
            rsp_result <= '0;
            rsp_ne     <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_hs_c) begin
                        if (req1_ready) begin
                            alu_opA    <= req1_opA;
                            alu_opB    <= req1_opB;
                            alu_opcode <= req1_opcode;
                            alu_shamt  <= req1_shamt;
                        end else begin
                            alu_opA    <= req0_opA;
                            alu_opB    <= req0_opB;
                            alu_opcode <= req0_opcode;
                            alu_shamt  <= req0_shamt;
                        end
                        owner      <= req1_ready;
                        last_grant <= req1_ready;
                        cnt        <= CNT_LOAD;
                        busy       <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_result <= alu_result;
                        rsp_ne     <= alu_ne;
                        rsp_lt     <= alu_lt;
                        rsp_ovf    <= alu_ovf;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                    end
                end
                S_RESP: begin
                    if (rsp_hs_c) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: three instances (round-robin, fixed priority, latency 3)
// with a reference ALU on each and a per-instance scoreboard of expected responses.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 3;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ne;
        logic         lt;
        logic         ovf;
    } alu_out_t;

    typedef struct packed {
        logic     chan;
        alu_out_t val;
    } sb_entry_t;

    logic         clock = 1'b0;
    logic         reset_n     [N];
    logic         req0_valid  [N];
    logic         req0_ready  [N];
    logic [W-1:0] req0_opA    [N];
    logic [W-1:0] req0_opB    [N];
    logic [4:0]   req0_opcode [N];
    logic [4:0]   req0_shamt  [N];
    logic         req1_valid  [N];
    logic         req1_ready  [N];
    logic [W-1:0] req1_opA    [N];
    logic [W-1:0] req1_opB    [N];
    logic [4:0]   req1_opcode [N];
    logic [4:0]   req1_shamt  [N];
    logic         rsp0_valid  [N];
    logic         rsp0_ready  [N];
    logic         rsp1_valid  [N];
    logic         rsp1_ready  [N];
    logic [W-1:0] rsp_result  [N];
    logic         rsp_ne      [N];
    logic         rsp_lt      [N];
    logic         rsp_ovf     [N];
    logic [W-1:0] alu_opA     [N];
    logic [W-1:0] alu_opB     [N];
    logic [4:0]   alu_opcode  [N];
    logic [4:0]   alu_shamt   [N];
    logic [W-1:0] alu_result  [N];
    logic         alu_ne      [N];
    logic         alu_lt      [N];
    logic         alu_ovf     [N];
    logic         busy        [N];

    int n_checks = 0;
    int n_fail   = 0;

    sb_entry_t sb      [N][$];
    int        gnt_log [N][$];

    always #5 clock = ~clock;

    function automatic alu_out_t alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [4:0] op, input logic [4:0] sh);
        alu_out_t o;
        o.ne  = (a != b);
        o.lt  = ($signed(a) < $signed(b));
        o.ovf = 1'b0;
        case (op)
            5'd0: begin
                o.res = a + b;
                o.ovf = (a[W-1] == b[W-1]) && (o.res[W-1] != a[W-1]);
            end
            5'd1: begin
                o.res = a - b;
                o.ovf = (a[W-1] != b[W-1]) && (o.res[W-1] != a[W-1]);
            end
            5'd2:    o.res = a & b;
            5'd3:    o.res = a | b;
            5'd4:    o.res = a << sh;
            5'd5:    o.res = W'($signed(a) >>> sh);
            default: o.res = '0;
        endcase
        return o;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_dut
        alu_share_arbiter #(
            .WIDTH         (W),
            .ALU_LATENCY   ((k == 2) ? 3 : 1),
            .PRIORITY_MODE ((k == 1) ? 1 : 0)
        ) u_dut (
            .clock       (clock),
            .reset_n     (reset_n[k]),
            .req0_valid  (req0_valid[k]),
            .req0_ready  (req0_ready[k]),
            .req0_opA    (req0_opA[k]),
            .req0_opB    (req0_opB[k]),
            .req0_opcode (req0_opcode[k]),
            .req0_shamt  (req0_shamt[k]),
            .req1_valid  (req1_valid[k]),
            .req1_ready  (req1_ready[k]),
            .req1_opA    (req1_opA[k]),
            .req1_opB    (req1_opB[k]),
            .req1_opcode (req1_opcode[k]),
            .req1_shamt  (req1_shamt[k]),
            .rsp0_valid  (rsp0_valid[k]),
            .rsp0_ready  (rsp0_ready[k]),
            .rsp1_valid  (rsp1_valid[k]),
            .rsp1_ready  (rsp1_ready[k]),
            .rsp_result  (rsp_result[k]),
            .rsp_ne      (rsp_ne[k]),
            .rsp_lt      (rsp_lt[k]),
            .rsp_ovf     (rsp_ovf[k]),
            .alu_opA     (alu_opA[k]),
            .alu_opB     (alu_opB[k]),
            .alu_opcode  (alu_opcode[k]),
            .alu_shamt   (alu_shamt[k]),
            .alu_result  (alu_result[k]),
            .alu_ne      (alu_ne[k]),
            .alu_lt      (alu_lt[k]),
            .alu_ovf     (alu_ovf[k]),
            .busy        (busy[k])
        );

        assign {alu_result[k], alu_ne[k], alu_lt[k], alu_ovf[k]} =
            alu_f(alu_opA[k], alu_opB[k], alu_opcode[k], alu_shamt[k]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_data"}, 64'(rsp_result[k] | alu_opA[k] | alu_opB[k]), 64'd0);
        check({tag, "_ctrl"}, 64'({busy[k], rsp0_valid[k], rsp1_valid[k], req0_ready[k],
                                   req1_ready[k], rsp_ne[k], rsp_lt[k], rsp_ovf[k],
                                   alu_opcode[k], alu_shamt[k]}), 64'd0);
    endtask

    task automatic do_reset(input int k);
        reset_n[k]    = 1'b0;
        req0_valid[k] = 1'b0;
        req1_valid[k] = 1'b0;
        rsp0_ready[k] = 1'b1;
        rsp1_ready[k] = 1'b1;
        sb[k].delete();
        gnt_log[k].delete();
        repeat (2) tick();
        reset_n[k] = 1'b1;
        tick();
    endtask

    task automatic set_req(input int k, input bit which, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] op, input logic [4:0] sh);
        if (which) begin
            req1_opA[k] = a; req1_opB[k] = b; req1_opcode[k] = op; req1_shamt[k] = sh;
            req1_valid[k] = 1'b1;
        end else begin
            req0_opA[k] = a; req0_opB[k] = b; req0_opcode[k] = op; req0_shamt[k] = sh;
            req0_valid[k] = 1'b1;
        end
    endtask

    // Returns at the negedge of the cycle whose rising edge completes the handshake.
    task automatic wait_ready(input int k, input bit which);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            ok = which ? (req1_valid[k] && req1_ready[k]) : (req0_valid[k] && req0_ready[k]);
        end
        check(which ? "hs_timeout_req1" : "hs_timeout_req0", 64'(ok), 64'd1);
    endtask

    task automatic drain(input int k);
        repeat (12) tick();
        check("sb_drained", 64'(sb[k].size()), 64'd0);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clock) begin : mon
        sb_entry_t e;
        for (int k = 0; k < N; k++) begin
            if (reset_n[k]) begin
                check("ready_onehot", 64'(req0_ready[k] & req1_ready[k]), 64'd0);
                check("rsp_onehot", 64'(rsp0_valid[k] & rsp1_valid[k]), 64'd0);
                if (req0_valid[k] && req0_ready[k]) begin
                    e.chan = 1'b0;
                    e.val  = alu_f(req0_opA[k], req0_opB[k], req0_opcode[k], req0_shamt[k]);
                    sb[k].push_back(e);
                    gnt_log[k].push_back(0);
                end
                if (req1_valid[k] && req1_ready[k]) begin
                    e.chan = 1'b1;
                    e.val  = alu_f(req1_opA[k], req1_opB[k], req1_opcode[k], req1_shamt[k]);
                    sb[k].push_back(e);
                    gnt_log[k].push_back(1);
                end
                if ((rsp0_valid[k] && rsp0_ready[k]) || (rsp1_valid[k] && rsp1_ready[k])) begin
                    if (sb[k].size() == 0) begin
                        check("rsp_unexpected", 64'(sb[k].size()), 64'd1);
                    end else begin
                        e = sb[k].pop_front();
                        check("rsp_chan", 64'(rsp1_valid[k]), 64'(e.chan));
                        check("rsp_result", 64'(rsp_result[k]), 64'(e.val.res));
                        check("rsp_flags", 64'({rsp_ne[k], rsp_lt[k], rsp_ovf[k]}),
                              64'({e.val.ne, e.val.lt, e.val.ovf}));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached before completion, got %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ones;
        for (int k = 0; k < N; k++) begin
            reset_n[k] = 1'b0;
            req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
            req0_opA[k] = '0; req0_opB[k] = '0; req0_opcode[k] = '0; req0_shamt[k] = '0;
            req1_opA[k] = '0; req1_opB[k] = '0; req1_opcode[k] = '0; req1_shamt[k] = '0;
            rsp0_ready[k] = 1'b1; rsp1_ready[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < N; k++) check_zero(k, "reset_state");
        repeat (2) tick();
        for (int k = 0; k < N; k++) reset_n[k] = 1'b1;
        tick();

        // add 5+7: response two cycles after the ready cycle
        set_req(0, 1'b0, 32'd5, 32'd7, 5'd0, 5'd0);
        wait_ready(0, 1'b0);
        tick();
        req0_valid[0] = 1'b0;
        @(negedge clock);
        check("t1_exec_rsp0_valid", 64'(rsp0_valid[0]), 64'd0);
        check("t1_exec_busy", 64'(busy[0]), 64'd1);
        @(negedge clock);
        check("t1_rsp0_valid", 64'(rsp0_valid[0]), 64'd1);
        check("t1_result", 64'(rsp_result[0]), 64'd12);
        check("t1_ovf", 64'(rsp_ovf[0]), 64'd0);
        check("t1_ne", 64'(rsp_ne[0]), 64'd1);
        drain(0);

        // subtract overflow at the most negative operand
        set_req(0, 1'b0, 32'h8000_0000, 32'd1, 5'd1, 5'd0);
        wait_ready(0, 1'b0);
        tick();
        req0_valid[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t2_result", 64'(rsp_result[0]), 64'h7FFF_FFFF);
        check("t2_ovf", 64'(rsp_ovf[0]), 64'd1);
        check("t2_valids", 64'({rsp0_valid[0], rsp1_valid[0]}), 64'b10);
        drain(0);

        // round-robin with both requesters continuously valid from reset
        do_reset(0);
        set_req(0, 1'b0, 32'd10, 32'd3, 5'd0, 5'd0);
        set_req(0, 1'b1, 32'h0000_00F0, 32'h0000_003C, 5'd2, 5'd0);
        for (int i = 0; i < 100 && gnt_log[0].size() < 4; i++) tick();
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        drain(0);
        check("t3_grant_count", 64'(gnt_log[0].size()), 64'd4);
        for (int i = 0; i < 4 && i < gnt_log[0].size(); i++)
            check("t3_grant_order", 64'(gnt_log[0][i]), 64'(i % 2));

        // fixed priority: req0 always wins
        do_reset(1);
        set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0);
        set_req(1, 1'b1, 32'd9, 32'd2, 5'd1, 5'd0);
        for (int i = 0; i < 100 && gnt_log[1].size() < 4; i++) tick();
        req0_valid[1] = 1'b0;
        req1_valid[1] = 1'b0;
        drain(1);
        check("t4_grant_count", 64'(gnt_log[1].size()), 64'd4);
        ones = 0;
        foreach (gnt_log[1][i]) ones += gnt_log[1][i];
        check("t4_req1_grants", 64'(ones), 64'd0);

        // response backpressure on channel 1 with req0 waiting
        do_reset(0);
        rsp1_ready[0] = 1'b0;
        set_req(0, 1'b1, 32'h0000_000F, 32'h0000_00F0, 5'd3, 5'd0);
        wait_ready(0, 1'b1);
        tick();
        req1_valid[0] = 1'b0;
        set_req(0, 1'b0, 32'd1, 32'd2, 5'd0, 5'd0);
        for (int i = 0; i < 10 && !rsp1_valid[0]; i++) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t5_hold_valid", 64'(rsp1_valid[0]), 64'd1);
            check("t5_hold_result", 64'(rsp_result[0]), 64'h0000_00FF);
            check("t5_hold_req0_ready", 64'(req0_ready[0]), 64'd0);
        end
        @(posedge clock);
        #1;
        rsp1_ready[0] = 1'b1;
        @(negedge clock);
        check("t5_hs_cycle_req0_ready", 64'(req0_ready[0]), 64'd0);
        @(negedge clock);
        check("t5_next_idle_req0_ready", 64'(req0_ready[0]), 64'd1);
        tick();
        req0_valid[0] = 1'b0;
        drain(0);

        // latency 3: alu_* stable from capture registers through EXEC
        do_reset(2);
        set_req(2, 1'b0, 32'h0000_0001, 32'h0000_0055, 5'd4, 5'd4);
        wait_ready(2, 1'b0);
        tick();
        req0_valid[2] = 1'b0;
        req0_opA[2] = 32'hDEAD_BEEF;
        req0_opcode[2] = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_alu_opA", 64'(alu_opA[2]), 64'h1);
            check("t6_alu_opB", 64'(alu_opB[2]), 64'h55);
            check("t6_alu_ctl", 64'({alu_opcode[2], alu_shamt[2]}), 64'({5'd4, 5'd4}));
            check("t6_exec_rsp0_valid", 64'(rsp0_valid[2]), 64'd0);
        end
        @(negedge clock);
        check("t6_rsp0_valid", 64'(rsp0_valid[2]), 64'd1);
        check("t6_result", 64'(rsp_result[2]), 64'h10);
        drain(2);

        // reset pulse mid-EXEC aborts the operation
        set_req(2, 1'b1, 32'h0000_0003, 32'h0000_0030, 5'd3, 5'd0);
        wait_ready(2, 1'b1);
        tick();
        set_req(2, 1'b0, 32'd4, 32'd4, 5'd0, 5'd0);
        tick();
        #2;
        reset_n[2] = 1'b0;
        #1;
        check_zero(2, "t6_async_reset");
        sb[2].delete();
        gnt_log[2].delete();
        repeat (2) tick();
        reset_n[2] = 1'b1;
        wait_ready(2, 1'b0);
        tick();
        req0_valid[2] = 1'b0;
        req1_valid[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t6_no_stale_rsp1", 64'(rsp1_valid[2]), 64'd0);
        end
        drain(2);
        check("t6_first_grant_req0", 64'(gnt_log[2].size() > 0 ? gnt_log[2][0] : -1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
